// File: rtl/imem_loader.sv
// imem_loader: boot-time sequencer that streams host words into instruction
// memory and steps the PC block through idle -> write -> execute.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   boot_req      level request to (re)start a program load
//   host_valid    host word valid
//   host_data     instruction word from the host
//   host_last     marks the final word of the program (with host_valid)
//   host_ready    loader accepts a word this cycle (LOAD only)
//   im_we         instruction memory write enable
//   im_addr       word-aligned byte address of the write
//   im_wdata      write data
//   wr_im         pulse to the PC block with the first write of a load
//   start         pulse to the PC block to begin execution from PC 0
//   busy          high in LOAD, FLUSH and START
//   done          high in RUN
//   err_overflow  high in ERR (program did not fit)
//   word_count    words accepted in the current or most recent load

module imem_loader #(
   parameter int IM_WORDS = 256,
   parameter int CNT_W    = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             boot_req,
   input  logic             host_valid,
   input  logic [31:0]      host_data,
   input  logic             host_last,
   output logic             host_ready,
   output logic             im_we,
   output logic [31:0]      im_addr,
   output logic [31:0]      im_wdata,
   output logic             wr_im,
   output logic             start,
   output logic             busy,
   output logic             done,
   output logic             err_overflow,
   output logic [CNT_W-1:0] word_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(IM_WORDS - 1);

   logic [2:0] state;
   logic [2:0] state_nx;
   logic       hs;
   logic       at_cap;
   logic       first;
   logic       enter_load;

   // Ready is a pure state decode so the host never sees a
   // combinational path from its own valid back to ready.
   assign host_ready = (state == S_LOAD);
   assign hs         = host_valid & host_ready;
   assign at_cap     = (word_count == LAST_SLOT);
   assign first      = (word_count == '0);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (boot_req)
               state_nx = S_LOAD;
         end
         S_LOAD: begin
            // The word taken in the last free slot is still written;
            // without a terminator there is nowhere left to go.
            if (hs) begin
               if (host_last)
                  state_nx = S_FLUSH;
               else if (at_cap)
                  state_nx = S_ERR;
            end
         end
         S_FLUSH: state_nx = S_START;
         S_START: state_nx = S_RUN;
         S_RUN: begin
            if (boot_req)
               state_nx = S_LOAD;
         end
         S_ERR: begin
            if (boot_req)
               state_nx = S_LOAD;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign enter_load = (state_nx == S_LOAD) && (state != S_LOAD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         word_count <= '0;
         im_we      <= 1'b0;
         wr_im      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
      end else begin
         state <= state_nx;
         im_we <= hs;
         wr_im <= hs & first;
         if (hs) begin
            im_addr    <= {30'(word_count), 2'b00};
            im_wdata   <= host_data;
            word_count <= word_count + CNT_W'(1);
         end else if (enter_load) begin
            word_count <= '0;
         end
      end
   end

   assign start        = (state == S_START);
   assign busy         = (state == S_LOAD) ||
                         (state == S_FLUSH) ||
                         (state == S_START);
   assign done         = (state == S_RUN);
   assign err_overflow = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a write scoreboard.
// Expected memory writes are queued as words are offered and popped as seen.

module tb_imem_loader;

   localparam int IMW = 4;
   localparam int CW  = 3;

   logic          clk;
   logic          rst;
   logic          boot_req;
   logic          host_valid;
   logic [31:0]   host_data;
   logic          host_last;
   logic          host_ready;
   logic          im_we;
   logic [31:0]   im_addr;
   logic [31:0]   im_wdata;
   logic          wr_im;
   logic          start;
   logic          busy;
   logic          done;
   logic          err_overflow;
   logic [CW-1:0] word_count;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic        f;
   } wr_t;

   wr_t q[$];
   int  vec;
   int  bad;
   int  exp_cnt;
   int  starts;

   imem_loader #(.IM_WORDS(IMW), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .boot_req     (boot_req),
      .host_valid   (host_valid),
      .host_data    (host_data),
      .host_last    (host_last),
      .host_ready   (host_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .wr_im        (wr_im),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .err_overflow (err_overflow),
      .word_count   (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock, then sample 1 time unit after the edge and score writes.
   task automatic step();
      wr_t w;
      @(posedge clk);
      #1;
      if (start === 1'b1)
         starts++;
      if (im_we === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            w = q.pop_front();
            chk("wr_addr", im_addr, w.a);
            chk("wr_data", im_wdata, w.d);
            chk("wr_im_pulse", wr_im, w.f);
         end
      end else begin
         chk("wr_im_idle", wr_im, 0);
      end
   endtask

   task automatic boot(input logic hold);
      boot_req = 1'b1;
      step();
      boot_req = hold;
      exp_cnt  = 0;
      chk("boot_ready", host_ready, 1);
      chk("boot_cnt", word_count, 0);
      chk("boot_busy", busy, 1);
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      wr_t w;
      host_valid = 1'b1;
      host_data  = d;
      host_last  = last;
      chk("send_ready", host_ready, 1);
      w.a = 32'(exp_cnt * 4);
      w.d = d;
      w.f = (exp_cnt == 0);
      q.push_back(w);
      exp_cnt++;
      step();
      host_valid = 1'b0;
      host_last  = 1'b0;
      chk("we_after_hs", im_we, 1);
   endtask

   task automatic gap();
      host_valid = 1'b0;
      step();
      chk("we_in_gap", im_we, 0);
   endtask

   // Called in the FLUSH cycle; walks START then RUN.
   task automatic finish_load(input int cnt);
      int s0;
      s0 = starts;
      chk("flush_busy", busy, 1);
      chk("flush_ready", host_ready, 0);
      chk("flush_start", start, 0);
      step();
      chk("start_pulse", start, 1);
      chk("start_busy", busy, 1);
      chk("start_we", im_we, 0);
      step();
      chk("run_start", start, 0);
      chk("run_done", done, 1);
      chk("run_busy", busy, 0);
      chk("run_cnt", word_count, cnt);
      chk("one_start", starts - s0, 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, host_ready, 0);
      chk({tag, "_we"}, im_we, 0);
      chk({tag, "_addr"}, im_addr, 0);
      chk({tag, "_wdata"}, im_wdata, 0);
      chk({tag, "_wr_im"}, wr_im, 0);
      chk({tag, "_start"}, start, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err_overflow, 0);
      chk({tag, "_cnt"}, word_count, 0);
   endtask

   initial begin
      int s0;
      vec        = 0;
      bad        = 0;
      exp_cnt    = 0;
      starts     = 0;
      rst        = 1'b1;
      boot_req   = 1'b0;
      host_valid = 1'b0;
      host_data  = 32'h0;
      host_last  = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk_reset_outs("rst");
      step();
      chk("idle_ready", host_ready, 0);

      // three-word back-to-back load
      boot(1'b0);
      send(32'h0000_0013, 1'b0);
      send(32'h0010_0093, 1'b0);
      send(32'h0020_0113, 1'b1);
      finish_load(3);

      // throttled host: valid 1,0,0,1,1
      boot(1'b0);
      send(32'hA000_0001, 1'b0);
      gap();
      gap();
      send(32'hA000_0002, 1'b0);
      send(32'hA000_0003, 1'b1);
      finish_load(3);

      // one-word program
      boot(1'b0);
      send(32'hDEAD_BEEF, 1'b1);
      chk("one_wr_im", wr_im, 1);
      finish_load(1);

      // overflow at capacity
      s0 = starts;
      boot(1'b0);
      send(32'h1111_1111, 1'b0);
      send(32'h2222_2222, 1'b0);
      send(32'h3333_3333, 1'b0);
      send(32'h4444_4444, 1'b0);
      chk("ovf_err", err_overflow, 1);
      chk("ovf_ready", host_ready, 0);
      chk("ovf_cnt", word_count, 4);
      chk("ovf_busy", busy, 0);
      host_valid = 1'b1;
      host_data  = 32'h5555_5555;
      step();
      chk("ovf_no_we", im_we, 0);
      chk("ovf_hold", err_overflow, 1);
      step();
      host_valid = 1'b0;
      chk("ovf_no_start", starts - s0, 0);
      chk("ovf_done", done, 0);
      boot(1'b0);
      chk("ovf_exit", err_overflow, 0);

      // reset one cycle after the second handshake
      send(32'h0BAD_0001, 1'b0);
      send(32'h0BAD_0002, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_outs("mid");
      host_valid = 1'b1;
      host_data  = 32'h0BAD_0003;
      step();
      chk("mid_idle_ready", host_ready, 0);
      chk("mid_idle_we", im_we, 0);
      step();
      chk("mid_idle_we2", im_we, 0);
      host_valid = 1'b0;

      // load to RUN, then reload with boot_req held through LOAD
      boot(1'b0);
      send(32'h0000_0001, 1'b1);
      finish_load(1);
      boot(1'b1);
      chk("reload_done", done, 0);
      send(32'hC0DE_0000, 1'b0);
      send(32'hC0DE_0004, 1'b1);
      chk("reload_flush", busy, 1);
      boot_req = 1'b0;
      finish_load(2);
      step();
      chk("reload_stay", done, 1);

      chk("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
